// File: rtl/mmem_responder_if.sv
// Byte-serial main-memory request/response bundle between the memory
// controller (master) and the memory-side responder (slave).
interface mmem_responder_if;
  logic        mmem_valid;
  logic        mmem_r_w;
  logic [31:0] mmem_addr;
  logic [31:0] mmem_data;
  logic [31:0] data_get;

  modport master (
    output mmem_valid, mmem_r_w, mmem_addr, mmem_data,
    input  data_get
  );

  modport slave (
    input  mmem_valid, mmem_r_w, mmem_addr, mmem_data,
    output data_get
  );
endinterface

// File: rtl/mmem_responder.sv
// Main-memory responder: byte RAM with one-cycle read latency, plus a
// DATA/STATUS register pair backed by TX and RX byte FIFOs for the console.
module mmem_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter logic [31:0] IO_ADDR    = 32'h0003_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  mmem_responder_if.slave   bus,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [31:0] STATUS_ADDR = IO_ADDR + 32'd4;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [7:0] ram     [RAM_DEPTH];
  logic [7:0] tx_mem  [FIFO_DEPTH];
  logic [7:0] rx_mem  [FIFO_DEPTH];

  logic [PTR_W-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic             ovf;

  logic [PTR_W-1:0] tx_rd_n, tx_wr_n, rx_rd_n, rx_wr_n;
  logic [CNT_W-1:0] tx_count_n, rx_count_n;
  logic [7:0]       tx_head_n;

  logic sel_data_c, sel_status_c, sel_ram_c;
  logic tx_full_c, rx_nonempty_c;
  logic tx_push_req_c, tx_push_c, tx_pop_c, tx_drop_c;
  logic rx_push_c, rx_pop_c, status_rd_c;
  logic [7:0] wbyte_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic unused_data_hi;

  // Address decode and per-cycle FIFO events
  assign wbyte_c        = bus.mmem_data[7:0];
  assign ram_addr_c     = bus.mmem_addr[ADDR_WIDTH-1:0];
  assign unused_data_hi = ^bus.mmem_data[31:8];

  assign sel_data_c   = bus.mmem_valid && (bus.mmem_addr == IO_ADDR);
  assign sel_status_c = bus.mmem_valid && (bus.mmem_addr == STATUS_ADDR);
  assign sel_ram_c    = bus.mmem_valid && !sel_data_c && !sel_status_c;

  assign tx_full_c     = (tx_count == FULL_CNT);
  assign rx_nonempty_c = (rx_count != '0);

  assign tx_pop_c      = tx_valid && tx_ready;
  assign tx_push_req_c = sel_data_c && bus.mmem_r_w;
  // A full FIFO still accepts a push when the sink frees a slot on the same edge
  assign tx_push_c     = tx_push_req_c && (!tx_full_c || tx_pop_c);
  assign tx_drop_c     = tx_push_req_c && tx_full_c && !tx_pop_c;

  assign rx_push_c   = rx_valid && rx_ready;
  assign rx_pop_c    = sel_data_c && !bus.mmem_r_w && rx_nonempty_c;
  assign status_rd_c = sel_status_c && !bus.mmem_r_w;

  // Next pointer/count state and the TX head that will be visible next cycle
  always_comb begin
    tx_rd_n    = tx_rd + PTR_W'(tx_pop_c);
    tx_wr_n    = tx_wr + PTR_W'(tx_push_c);
    tx_count_n = tx_count + CNT_W'(tx_push_c) - CNT_W'(tx_pop_c);
    rx_rd_n    = rx_rd + PTR_W'(rx_pop_c);
    rx_wr_n    = rx_wr + PTR_W'(rx_push_c);
    rx_count_n = rx_count + CNT_W'(rx_push_c) - CNT_W'(rx_pop_c);
    tx_head_n  = 8'h00;
    if (tx_count_n != '0) begin
      // The byte being written this edge becomes the head when it lands in the read slot
      if (tx_push_c && (tx_wr == tx_rd_n)) tx_head_n = wbyte_c;
      else                                 tx_head_n = tx_mem[tx_rd_n];
    end
  end

  // Storage arrays: not reset; writes suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (rst && sel_ram_c && bus.mmem_r_w) ram[ram_addr_c] <= wbyte_c;
    if (rst && tx_push_c)                 tx_mem[tx_wr]   <= wbyte_c;
    if (rst && rx_push_c)                 rx_mem[rx_wr]   <= rx_data;
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_rd        <= '0;
      tx_wr        <= '0;
      tx_count     <= '0;
      rx_rd        <= '0;
      rx_wr        <= '0;
      rx_count     <= '0;
      ovf          <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      rx_ready     <= 1'b0;
      bus.data_get <= 32'h0;
    end else begin
      tx_rd    <= tx_rd_n;
      tx_wr    <= tx_wr_n;
      tx_count <= tx_count_n;
      rx_rd    <= rx_rd_n;
      rx_wr    <= rx_wr_n;
      rx_count <= rx_count_n;
      tx_valid <= (tx_count_n != '0);
      tx_data  <= tx_head_n;
      rx_ready <= (rx_count_n != FULL_CNT);

      if (tx_drop_c)        ovf <= 1'b1;
      else if (status_rd_c) ovf <= 1'b0;

      if (bus.mmem_valid && !bus.mmem_r_w) begin
        if (sel_ram_c)
          bus.data_get <= {24'h0, ram[ram_addr_c]};
        else if (sel_data_c)
          bus.data_get <= {24'h0, (rx_nonempty_c ? rx_mem[rx_rd] : 8'h00)};
        else
          bus.data_get <= {29'h0, ovf, tx_full_c, rx_nonempty_c};
      end
    end
  end

endmodule

// File: tb/tb_mmem_responder.sv
// Directed bench for mmem_responder: RAM, address wrap, TX/RX console FIFOs
// and mid-operation reset.
module tb_mmem_responder;

  localparam logic [31:0] DATA_A   = 32'h0003_0000;
  localparam logic [31:0] STATUS_A = 32'h0003_0004;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  int checks   = 0;
  int failures = 0;

  mmem_responder_if bus ();

  mmem_responder #(
    .ADDR_WIDTH (17),
    .IO_ADDR    (32'h0003_0000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    bus.mmem_valid = 1'b1;
    bus.mmem_r_w   = 1'b1;
    bus.mmem_addr  = a;
    bus.mmem_data  = {24'hABCDEF, d};
    tick();
    bus.mmem_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] q);
    bus.mmem_valid = 1'b1;
    bus.mmem_r_w   = 1'b0;
    bus.mmem_addr  = a;
    tick();
    q = bus.data_get;
    bus.mmem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (bus.data_get !== 32'h0) begin failures++; $display("FAIL reset_data_get: got %h expected %h", bus.data_get, 32'h0); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
    rst = 1'b1;
    tick();
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rx_ready_after_reset: got %b expected 1", rx_ready); end
  endtask

  task automatic test_ram_roundtrip();
    logic [7:0] e;
    for (int i = 0; i < 4; i++) bus_write(32'h100 + 32'(i), 8'((i + 1) * 17));
    // Back-to-back reads, one request per cycle
    for (int i = 0; i < 4; i++) begin
      bus.mmem_valid = 1'b1;
      bus.mmem_r_w   = 1'b0;
      bus.mmem_addr  = 32'h100 + 32'(i);
      tick();
      e = 8'((i + 1) * 17);
      checks++;
      if (bus.data_get !== {24'h0, e}) begin
        failures++; $display("FAIL ram_read[%0d]: got %h expected %h", i, bus.data_get, {24'h0, e});
      end
    end
    bus.mmem_valid = 1'b0;
    tick();
    checks++; if (bus.data_get !== 32'h44) begin failures++; $display("FAIL data_get_hold: got %h expected %h", bus.data_get, 32'h44); end
  endtask

  task automatic test_wrap();
    logic [31:0] q;
    bus_write(32'h0002_0005, 8'hAB);
    bus_read(32'h0000_0005, q);
    checks++; if (q !== 32'hAB) begin failures++; $display("FAIL addr_wrap: got %h expected %h", q, 32'hAB); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] q;
    tx_ready = 1'b0;
    bus_write(DATA_A, 8'h01);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin failures++; $display("FAIL tx_first_push: got valid=%b data=%h expected valid=1 data=01", tx_valid, tx_data); end
    for (int i = 2; i <= 9; i++) bus_write(DATA_A, 8'(i));
    bus_read(STATUS_A, q);
    checks++; if (q !== 32'h6) begin failures++; $display("FAIL status_ovf: got %h expected %h", q, 32'h6); end
    bus_read(STATUS_A, q);
    checks++; if (q !== 32'h2) begin failures++; $display("FAIL status_ovf_cleared: got %h expected %h", q, 32'h2); end
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        failures++; $display("FAIL tx_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, 8'(i));
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_empty_after_drain: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] q;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(DATA_A, 8'h10 + 8'(i));
    // Write into the full FIFO on the same edge the sink takes 0x10
    tx_ready = 1'b1;
    bus_write(DATA_A, 8'h55);
    tx_ready = 1'b0;
    bus_read(STATUS_A, q);
    checks++; if (q !== 32'h2) begin failures++; $display("FAIL full_push_pop_status: got %h expected %h", q, 32'h2); end
    tx_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h10 + 8'(i)) begin
        failures++; $display("FAIL full_drain[%0d]: got valid=%b data=%h expected %h", i, tx_valid, tx_data, 8'h10 + 8'(i));
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin failures++; $display("FAIL full_drain_8th: got valid=%b data=%h expected 55", tx_valid, tx_data); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL full_drain_empty: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    logic [31:0] q;
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    tick();
    rx_data  = 8'h42;
    tick();
    rx_valid = 1'b0;
    bus_read(STATUS_A, q);
    checks++; if (q !== 32'h1) begin failures++; $display("FAIL rx_status: got %h expected %h", q, 32'h1); end
    bus_read(DATA_A, q);
    checks++; if (q !== 32'h41) begin failures++; $display("FAIL rx_read0: got %h expected %h", q, 32'h41); end
    bus_read(DATA_A, q);
    checks++; if (q !== 32'h42) begin failures++; $display("FAIL rx_read1: got %h expected %h", q, 32'h42); end
    bus_read(DATA_A, q);
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL rx_read_empty: got %h expected %h", q, 32'h0); end
    // Fill to capacity, then offer one more byte that must be refused
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h60 + 8'(i);
      tick();
      checks++;
      if (rx_ready !== (i < 7)) begin
        failures++; $display("FAIL rx_ready_fill[%0d]: got %b expected %b", i, rx_ready, (i < 7));
      end
    end
    rx_data = 8'h99;
    tick();
    rx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_read(DATA_A, q);
      checks++;
      if (q !== {24'h0, 8'h60 + 8'(i)}) begin
        failures++; $display("FAIL rx_fill_read[%0d]: got %h expected %h", i, q, {24'h0, 8'h60 + 8'(i)});
      end
    end
    bus_read(DATA_A, q);
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL rx_overfill_refused: got %h expected %h", q, 32'h0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    bus_write(32'h200, 8'h5A);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(DATA_A, 8'hC0 + 8'(i));
    bus_read(32'h200, q);
    // Read in flight when reset hits
    bus.mmem_valid = 1'b1;
    bus.mmem_r_w   = 1'b0;
    bus.mmem_addr  = 32'h100;
    rst = 1'b0;
    tick();
    bus.mmem_valid = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL midreset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (bus.data_get !== 32'h0) begin failures++; $display("FAIL midreset_data_get: got %h expected %h", bus.data_get, 32'h0); end
    rst = 1'b1;
    tick();
    bus_read(STATUS_A, q);
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL midreset_status: got %h expected %h", q, 32'h0); end
    bus_read(32'h200, q);
    checks++; if (q !== 32'h5A) begin failures++; $display("FAIL midreset_ram: got %h expected %h", q, 32'h5A); end
  endtask

  initial begin
    clk            = 1'b0;
    rst            = 1'b0;
    tx_ready       = 1'b0;
    rx_valid       = 1'b0;
    rx_data        = 8'h00;
    bus.mmem_valid = 1'b0;
    bus.mmem_r_w   = 1'b0;
    bus.mmem_addr  = 32'h0;
    bus.mmem_data  = 32'h0;
    #1;
    test_reset();
    test_ram_roundtrip();
    test_wrap();
    test_tx_overflow();
    test_full_push_pop();
    test_rx();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmem_responder.md
# mmem_responder

Byte-serial main-memory responder: the memory-side end of the controller's `mmem_*` interface. It serves one byte per cycle from an on-chip byte RAM. Two I/O registers above the RAM give the CPU a console path: a TX FIFO drained by a valid/ready sink and an RX FIFO filled by a valid/ready source. Sits between the CPU-side memory controller and the simulation/FPGA top level.

## Interface
- `ADDR_WIDTH`, 17, RAM address bits (RAM = 2^ADDR_WIDTH bytes).
- `IO_ADDR`, 32'h0003_0000, data register address; status register is at `IO_ADDR+4`.
- `FIFO_DEPTH`, 8, depth of TX and RX FIFOs; must be a power of 2, ≥2.

- `clk`  input  1  single clock, all logic on posedge.
- `rst`  input  1  synchronous reset, active-low (reset when 0 at posedge).
- `mmem_valid`  input  1  request strobe, one byte transfer per cycle it is high.
- `mmem_r_w`  input  1  0 = read, 1 = write.
- `mmem_addr`  input  32  byte address.
- `mmem_data`  input  32  write byte in [7:0]; [31:8] ignored.
- `data_get`  output  32  read byte in [7:0]; [31:8] always 0.
- `tx_data`  output  8  head of TX FIFO.
- `tx_valid`  output  1  TX FIFO non-empty.
- `tx_ready`  input  1  sink accepts `tx_data` when high with `tx_valid`.
- `rx_data`  input  8  byte from source.
- `rx_valid`  input  1  source offers `rx_data`.
- `rx_ready`  output  1  RX FIFO not full.

## Operation
- Address decode, only when `mmem_valid`=1, full 32-bit compare:
  - `IO_ADDR` is DATA.
  - `IO_ADDR+4` is STATUS.
  - Any other address is RAM at `mmem_addr[ADDR_WIDTH-1:0]`; upper bits are ignored, so addresses wrap.
- RAM write: `ram[a] <= mmem_data[7:0]`.
- RAM read: `data_get <= {24'b0, ram[a]}`.
- DATA write: push byte into TX FIFO.
  - If full with no TX pop this cycle, the byte is dropped and sticky `ovf` is set.
  - If full with a TX pop this cycle, the push is accepted.
- DATA read: return RX head and pop. If RX is empty, return 0x00 and pop nothing.
- STATUS read returns {29'b0, `ovf`, tx_full, rx_nonempty} and clears `ovf` on the same edge. A set and a clear in the same cycle cannot occur, because a transfer is a read or a write, never both.
- STATUS write: ignored.
- `mmem_valid`=0: no RAM or FIFO access; `data_get` holds its value.
- TX pop: `tx_valid & tx_ready`.
- RX push: `rx_valid & rx_ready`. `rx_ready` may also be high on a cycle when an RX pop occurs only if the FIFO is not full; it is not combinationally tied to the pop.
- FIFOs: circular buffers with log2(FIFO_DEPTH)-bit pointers that wrap, and a count of width log2(FIFO_DEPTH)+1. A simultaneous push and pop leaves the count unchanged.
- RAM contents are not initialised by reset. Simulation may preload them with `$readmemh`.

## Timing
- Read latency is 1 cycle. A request sampled at posedge N drives `data_get` after posedge N, and the value holds until the next valid read.
- Back-to-back reads one per cycle are supported: for a 4-byte LW, addresses A..A+3 on cycles N..N+3 return bytes on N+1..N+4.
- A write takes effect at its posedge. A read of the same address on the next cycle returns the new byte.
- Effects of a DATA write:
  - `tx_valid` rises 1 cycle after the write posedge.
  - A byte pushed into an empty TX FIFO appears on `tx_data` in that same cycle.
- After an RX push at posedge N, the byte is readable by a DATA read sampled at N+1 or later.
- Reset (rst=0 at posedge):
  - Outputs: `data_get`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=0.
  - State: FIFO pointers and counts are 0, `ovf`=0.
  - `rx_ready` returns to 1 on the first cycle after reset is released.
  - Any transfer in flight is discarded; the controller must restart it.
- Status bits reflect FIFO state before the current cycle's push or pop.

## Test plan
- RAM round trip: write 0x11,0x22,0x33,0x44 to 0x100..0x103, then read them back-to-back → `data_get` = 0x11,0x22,0x33,0x44 on the 4 cycles following each read request; [31:8]=0.
- Wrap: write 0xAB to 0x0002_0005 with ADDR_WIDTH=17, then read 0x0000_0005 → 0xAB.
- TX overflow:
  - With `tx_ready`=0, write 9 bytes 0x01..0x09 to DATA → STATUS read returns 0x6 (ovf, tx_full).
  - A second STATUS read returns 0x2.
  - Raise `tx_ready` → `tx_data` sequence is 0x01..0x08, then `tx_valid`=0.
- Full-FIFO simultaneous push/pop: with TX full and `tx_ready`=1, write 0x55 → accepted, `ovf` stays 0, and 0x55 is the 8th byte drained.
- RX path:
  - Drive 0x41, 0x42 via `rx_valid` → STATUS bit0=1.
  - DATA reads return 0x41 then 0x42.
  - A third DATA read returns 0x00.
  - `rx_ready` drops after 8 pushed and unread bytes.
- Reset mid-operation: assert rst=0 while TX holds 3 bytes and a read is in flight → next cycle `tx_valid`=0, `data_get`=0, STATUS=0x0; RAM byte written before reset still reads back correctly.
